// File: rtl/loop_row_accumulator_if.sv
`default_nettype none
// ============================================================================
// Module      : loop_row_accumulator_if
// Description : Bundle of the loop-control strobes, the sample/read inputs and
//               the counter/accumulator/read-back outputs exchanged between the
//               loop-control FSM (master) and loop_row_accumulator (slave).
//               Optional build macro: ACC_SAT_EN adds the sticky ovf flag.
// Signals     : reset_j, en, WR0, WR1 - FSM strobes (master -> slave)
//               data_in [DATA_W]      - sample / coefficient (master -> slave)
//               rd_addr [3]           - row-buffer read index (master -> slave)
//               i [4], j [3]          - outer / inner counts (slave -> master)
//               coeff [DATA_W]        - latched coefficient (slave -> master)
//               acc [ACC_W]           - running row sum (slave -> master)
//               row_valid, done, err  - status flags (slave -> master)
//               rd_data [ACC_W]       - registered read data (slave -> master)
//               ovf                   - saturation flag, ACC_SAT_EN only
// Revision    : 1.0 - initial release
// ============================================================================
interface loop_row_accumulator_if #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 12
);
    logic              reset_j;
    logic              en;
    logic              WR0;
    logic              WR1;
    logic [DATA_W-1:0] data_in;
    logic [2:0]        rd_addr;
    logic [3:0]        i;
    logic [2:0]        j;
    logic [DATA_W-1:0] coeff;
    logic [ACC_W-1:0]  acc;
    logic              row_valid;
    logic              done;
    logic              err;
    logic [ACC_W-1:0]  rd_data;
`ifdef ACC_SAT_EN
    logic              ovf;

    modport master (
        output reset_j, en, WR0, WR1, data_in, rd_addr,
        input  i, j, coeff, acc, row_valid, done, err, rd_data, ovf
    );

    modport slave (
        input  reset_j, en, WR0, WR1, data_in, rd_addr,
        output i, j, coeff, acc, row_valid, done, err, rd_data, ovf
    );
`else
    modport master (
        output reset_j, en, WR0, WR1, data_in, rd_addr,
        input  i, j, coeff, acc, row_valid, done, err, rd_data
    );

    modport slave (
        input  reset_j, en, WR0, WR1, data_in, rd_addr,
        output i, j, coeff, acc, row_valid, done, err, rd_data
    );
`endif
endinterface
`default_nettype wire

// File: rtl/loop_row_accumulator.sv
`default_nettype none
// ============================================================================
// Module      : loop_row_accumulator
// Description : Datapath driven by the loop-control FSM. Decodes the strobes
//               reset_j/en/WR0/WR1 into LOAD, IDLE, ROW_START, STEP and
//               ROW_END phases, runs the inner counter j and the outer counter
//               i, accumulates data_in across a row and commits one sum per
//               row into a row buffer read back through a registered port.
//               Optional build macro: ACC_SAT_EN - STEP saturates acc at its
//               maximum instead of wrapping and drives the sticky ovf flag.
// Ports       : clk_in  - clock
//               reset   - synchronous, active-high
//               bus     - loop_row_accumulator_if.slave (strobes, data_in,
//                         rd_addr in; i, j, coeff, acc, row_valid, done, err,
//                         rd_data [, ovf] out)
// Revision    : 1.0 - initial release
// ============================================================================
module loop_row_accumulator #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 12,
    parameter int J_MAX  = 6,
    parameter int I_MAX  = 8
) (
    input  wire logic               clk_in,
    input  wire logic               reset,
    loop_row_accumulator_if.slave   bus
);

    localparam logic [3:0] C_I_MAX = 4'(I_MAX);
    localparam logic [2:0] C_J_MAX = 3'(J_MAX);

    // Strobe pattern {WR0, WR1, en, reset_j} for each legal phase.
    localparam logic [3:0] C_PAT_LOAD      = 4'b1000;
    localparam logic [3:0] C_PAT_IDLE      = 4'b0000;
    localparam logic [3:0] C_PAT_ROW_START = 4'b1111;
    localparam logic [3:0] C_PAT_STEP      = 4'b1110;
    localparam logic [3:0] C_PAT_ROW_END   = 4'b1101;

    typedef enum logic [2:0] {
        PH_IDLE      = 3'd0,
        PH_LOAD      = 3'd1,
        PH_ROW_START = 3'd2,
        PH_STEP      = 3'd3,
        PH_ROW_END   = 3'd4,
        PH_ILLEGAL   = 3'd5
    } phase_t;

    phase_t            w_phase;
    logic [3:0]        w_strobes;

    logic [3:0]        r_i;
    logic [2:0]        r_j;
    logic [DATA_W-1:0] r_coeff;
    logic [ACC_W-1:0]  r_acc;
    logic              r_row_valid;
    logic              r_done;
    logic              r_err;
    logic [ACC_W-1:0]  r_rd_data;
    logic [ACC_W-1:0]  r_rowbuf [I_MAX];

    logic [ACC_W-1:0]  w_data_ext;
    logic [ACC_W-1:0]  w_acc_next;
    logic              w_step_live;
    logic              w_wr_en;
    logic [3:0]        w_wr_idx;
    logic [ACC_W-1:0]  w_rd_word;

    // ------------------------------------------------------------------
    // Phase decode
    // ------------------------------------------------------------------
    assign w_strobes = {bus.WR0, bus.WR1, bus.en, bus.reset_j};

    always_comb begin
        w_phase = PH_ILLEGAL;
        case (w_strobes)
            C_PAT_LOAD:      w_phase = PH_LOAD;
            C_PAT_IDLE:      w_phase = PH_IDLE;
            C_PAT_ROW_START: w_phase = PH_ROW_START;
            C_PAT_STEP:      w_phase = PH_STEP;
            C_PAT_ROW_END:   w_phase = PH_ROW_END;
            default:         w_phase = PH_ILLEGAL;
        endcase
    end

    // ------------------------------------------------------------------
    // Accumulator arithmetic (data_in zero-extended to ACC_W)
    // ------------------------------------------------------------------
    assign w_data_ext  = {{(ACC_W-DATA_W){1'b0}}, bus.data_in};

    // The cycle on which j has already reached J_MAX adds nothing, so each
    // row accumulates exactly J_MAX samples however long STEP is held.
    assign w_step_live = (w_phase == PH_STEP) && (r_j < C_J_MAX);

`ifdef ACC_SAT_EN
    logic [ACC_W:0] w_sum;
    logic           r_ovf;

    assign w_sum      = {1'b0, r_acc} + {1'b0, w_data_ext};
    assign w_acc_next = w_sum[ACC_W] ? {ACC_W{1'b1}} : w_sum[ACC_W-1:0];

    always_ff @(posedge clk_in) begin
        if (reset) begin
            r_ovf <= 1'b0;
        end else if (w_phase == PH_LOAD) begin
            r_ovf <= 1'b0;
        end else if (w_step_live && w_sum[ACC_W]) begin
            r_ovf <= 1'b1;
        end
    end

    assign bus.ovf = r_ovf;
`else
    assign w_acc_next = r_acc + w_data_ext;
`endif

    // ------------------------------------------------------------------
    // Counters, accumulator and status flags
    // ------------------------------------------------------------------
    always_ff @(posedge clk_in) begin
        if (reset) begin
            r_i         <= 4'd0;
            r_j         <= 3'd0;
            r_coeff     <= '0;
            r_acc       <= '0;
            r_row_valid <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_row_valid <= 1'b0;
            case (w_phase)
                PH_LOAD: begin
                    r_i     <= 4'd0;
                    r_j     <= 3'd0;
                    r_acc   <= '0;
                    r_done  <= 1'b0;
                    r_coeff <= bus.data_in;
                end
                PH_ROW_START: begin
                    r_j   <= 3'd0;
                    r_acc <= '0;
                    if (r_i < C_I_MAX) begin
                        r_i <= r_i + 4'd1;
                    end
                end
                PH_STEP: begin
                    if (w_step_live) begin
                        r_acc <= w_acc_next;
                        r_j   <= r_j + 3'd1;
                    end
                end
                PH_ROW_END: begin
                    // No row has been opened yet: nothing to commit, so no
                    // row_valid pulse either, only the error flag.
                    if (r_i == 4'd0) begin
                        r_err <= 1'b1;
                    end else begin
                        r_row_valid <= 1'b1;
                        if (r_i == C_I_MAX) begin
                            r_done <= 1'b1;
                        end
                    end
                end
                PH_ILLEGAL: begin
                    r_err <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Row buffer: row n is held in entry n-1 because i counts rows from 1
    // ------------------------------------------------------------------
    assign w_wr_en  = (w_phase == PH_ROW_END) && (r_i != 4'd0);
    assign w_wr_idx = r_i - 4'd1;

    always_ff @(posedge clk_in) begin
        for (int k = 0; k < I_MAX; k++) begin
            if (reset) begin
                r_rowbuf[k] <= '0;
            end else if (w_wr_en && (w_wr_idx == 4'(k))) begin
                r_rowbuf[k] <= r_acc;
            end
        end
    end

    // Read mux: indices with no backing entry fall through to zero.
    always_comb begin
        w_rd_word = '0;
        for (int k = 0; k < I_MAX; k++) begin
            if (bus.rd_addr == 3'(k)) begin
                w_rd_word = r_rowbuf[k];
            end
        end
    end

    // Registered read port; a same-cycle write to the addressed row is not
    // yet visible, so the old contents are returned.
    always_ff @(posedge clk_in) begin
        if (reset) begin
            r_rd_data <= '0;
        end else begin
            r_rd_data <= w_rd_word;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.i         = r_i;
    assign bus.j         = r_j;
    assign bus.coeff     = r_coeff;
    assign bus.acc       = r_acc;
    assign bus.row_valid = r_row_valid;
    assign bus.done      = r_done;
    assign bus.err       = r_err;
    assign bus.rd_data   = r_rd_data;

endmodule
`default_nettype wire

// File: tb/tb_loop_row_accumulator.sv
`default_nettype none
// ============================================================================
// Module      : tb_loop_row_accumulator
// Description : Self-checking bench for loop_row_accumulator. A driver issues
//               directed and random strobe sequences and updates a behavioural
//               model; expected outputs go into queues that a separate monitor
//               pops and compares on the falling edge. Honours ACC_SAT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_loop_row_accumulator;

    localparam int DATA_W  = 8;
    localparam int ACC_W   = 8;
    localparam int J_MAX   = 6;
    localparam int I_MAX   = 8;
    localparam int ACC_MAX = (1 << ACC_W) - 1;

    localparam logic [3:0] S_LOAD = 4'b1000;
    localparam logic [3:0] S_IDLE = 4'b0000;
    localparam logic [3:0] S_RS   = 4'b1111;
    localparam logic [3:0] S_STEP = 4'b1110;
    localparam logic [3:0] S_RE   = 4'b1101;

    typedef struct {
        int i; int j; int coeff; int acc;
        int rv; int done; int err; int ovf; int rd;
    } exp_t;

    typedef struct { int idx; int sum; } row_t;

    logic clk_in;
    logic reset;
    int   checks   = 0;
    int   failures = 0;

    exp_t exp_q[$];
    row_t row_q[$];

    // Behavioural model state
    int m_i, m_j, m_coeff, m_acc, m_rv, m_done, m_err, m_ovf, m_rd;
    int m_buf [I_MAX];

    loop_row_accumulator_if #(.DATA_W(DATA_W), .ACC_W(ACC_W)) bus ();

    loop_row_accumulator #(
        .DATA_W(DATA_W), .ACC_W(ACC_W), .J_MAX(J_MAX), .I_MAX(I_MAX)
    ) dut (
        .clk_in (clk_in),
        .reset  (reset),
        .bus    (bus)
    );

    initial begin
        clk_in = 1'b0;
        forever #5 clk_in = ~clk_in;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Applies one clock edge worth of behaviour to the model.
    task automatic model(input bit rst, input logic [3:0] s, input int d, input int ra);
        int sum;
        if (rst) begin
            m_i = 0; m_j = 0; m_coeff = 0; m_acc = 0; m_rv = 0;
            m_done = 0; m_err = 0; m_ovf = 0; m_rd = 0;
            for (int k = 0; k < I_MAX; k++) m_buf[k] = 0;
            return;
        end
        m_rd = (ra < I_MAX) ? m_buf[ra] : 0;
        m_rv = 0;
        if (s == S_LOAD) begin
            m_i = 0; m_j = 0; m_acc = 0; m_done = 0; m_ovf = 0; m_coeff = d;
        end else if (s == S_IDLE) begin
            // nothing changes
        end else if (s == S_RS) begin
            m_j = 0; m_acc = 0;
            if (m_i < I_MAX) m_i++;
        end else if (s == S_STEP) begin
            if (m_j < J_MAX) begin
                sum = m_acc + d;
`ifdef ACC_SAT_EN
                if (sum > ACC_MAX) begin
                    sum   = ACC_MAX;
                    m_ovf = 1;
                end
`else
                sum = sum % (ACC_MAX + 1);
`endif
                m_acc = sum;
                m_j++;
            end
        end else if (s == S_RE) begin
            if (m_i == 0) begin
                m_err = 1;
            end else begin
                m_buf[m_i-1] = m_acc;
                m_rv = 1;
                if (m_i == I_MAX) m_done = 1;
                row_q.push_back('{idx: m_i - 1, sum: m_acc});
            end
        end else begin
            m_err = 1;
        end
    endtask

    task automatic step(input bit rst, input logic [3:0] s, input int d, input int ra);
        exp_t e;
        reset       = rst;
        bus.WR0     = s[3];
        bus.WR1     = s[2];
        bus.en      = s[1];
        bus.reset_j = s[0];
        bus.data_in = 8'(d);
        bus.rd_addr = 3'(ra);
        @(posedge clk_in);
        model(rst, s, d, ra);
        e = '{i: m_i, j: m_j, coeff: m_coeff, acc: m_acc, rv: m_rv,
              done: m_done, err: m_err, ovf: m_ovf, rd: m_rd};
        exp_q.push_back(e);
        #1;
    endtask

    function automatic logic [3:0] rand_illegal();
        logic [3:0] s;
        do begin
            s = 4'($urandom_range(0, 15));
        end while (s == S_LOAD || s == S_IDLE || s == S_RS || s == S_STEP || s == S_RE);
        return s;
    endfunction

    // Monitor: compares every presented cycle against the queued expectation.
    initial begin
        exp_t e;
        row_t r;
        forever begin
            @(negedge clk_in);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("i",         32'(bus.i),         32'(e.i));
                chk("j",         32'(bus.j),         32'(e.j));
                chk("coeff",     32'(bus.coeff),     32'(e.coeff));
                chk("acc",       32'(bus.acc),       32'(e.acc));
                chk("row_valid", 32'(bus.row_valid), 32'(e.rv));
                chk("done",      32'(bus.done),      32'(e.done));
                chk("err",       32'(bus.err),       32'(e.err));
                chk("rd_data",   32'(bus.rd_data),   32'(e.rd));
`ifdef ACC_SAT_EN
                chk("ovf",       32'(bus.ovf),       32'(e.ovf));
`endif
                if (bus.row_valid === 1'b1) begin
                    if (row_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL row_commit actual=unexpected_pulse expected=none t=%0t", $time);
                    end else begin
                        r = row_q.pop_front();
                        chk("row_sum", 32'(bus.acc), 32'(r.sum));
                        chk("row_idx", 32'(bus.i) - 32'd1, 32'(r.idx));
                    end
                end
            end
        end
    end

    initial begin
        #1_000_000;
        failures++;
        $display("FAIL watchdog actual=timeout expected=finish t=%0t", $time);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        int n;
        // 1: reset then LOAD 5
        step(1, S_IDLE, 0, 0);
        step(1, S_IDLE, 0, 0);
        step(0, S_LOAD, 8'h05, 0);
        @(negedge clk_in);
        chk("t1_coeff", 32'(bus.coeff), 32'd5);
        chk("t1_i", 32'(bus.i), 32'd0);

        // ROW_END with no open row: error, nothing committed
        step(0, S_RE, 0, 0);
        step(1, S_IDLE, 0, 0);

        // 2: one row of 1..7, the seventh sample is not added
        step(0, S_RS, 0, 0);
        for (int k = 1; k <= 7; k++) step(0, S_STEP, k, 0);
        step(0, S_RE, 0, 0);
        @(negedge clk_in);
        chk("t2_acc", 32'(bus.acc), 32'd21);
        chk("t2_j", 32'(bus.j), 32'd6);
        chk("t2_i", 32'(bus.i), 32'd1);
        step(0, S_IDLE, 0, 0);
        step(0, S_IDLE, 0, 0);
        @(negedge clk_in);
        chk("t2_rowbuf0", 32'(bus.rd_data), 32'd21);

        // 3: eight full rows of 10, then read back, saturate i, LOAD clears
        step(0, S_LOAD, 0, 0);
        for (int r = 0; r < I_MAX; r++) begin
            step(0, S_RS, 0, 0);
            for (int k = 0; k < 7; k++) step(0, S_STEP, 10, 0);
            step(0, S_RE, 0, 0);
        end
        @(negedge clk_in);
        chk("t3_done", 32'(bus.done), 32'd1);
        chk("t3_i", 32'(bus.i), 32'd8);
        for (int a = 0; a < I_MAX; a++) step(0, S_IDLE, 0, a);
        step(0, S_IDLE, 0, 0);
        step(0, S_RS, 0, 3);
        @(negedge clk_in);
        chk("t3_i_sat", 32'(bus.i), 32'd8);
        step(0, S_LOAD, 0, 7);
        @(negedge clk_in);
        chk("t3_done_clr", 32'(bus.done), 32'd0);

        // 4: wrap (or saturate) with 8'hFF
        step(0, S_RS, 0, 0);
        step(0, S_STEP, 8'hFF, 0);
        step(0, S_STEP, 8'hFF, 0);
        @(negedge clk_in);
`ifdef ACC_SAT_EN
        chk("t4_acc_sat", 32'(bus.acc), 32'hFF);
        chk("t4_ovf", 32'(bus.ovf), 32'd1);
`else
        chk("t4_acc_wrap", 32'(bus.acc), 32'hFE);
`endif

        // 5: illegal strobe mid-row; err survives LOAD
        step(1, S_IDLE, 0, 0);
        step(0, S_LOAD, 3, 0);
        step(0, S_RS, 0, 0);
        for (int k = 0; k < 3; k++) step(0, S_STEP, 4, 0);
        step(0, 4'b0100, 0, 0);
        @(negedge clk_in);
        chk("t5_err", 32'(bus.err), 32'd1);
        chk("t5_acc_held", 32'(bus.acc), 32'd12);
        step(0, S_LOAD, 9, 0);
        @(negedge clk_in);
        chk("t5_err_sticky", 32'(bus.err), 32'd1);

        // 6: reset in STEP with j=3, acc=9
        step(0, S_RS, 0, 0);
        for (int k = 2; k <= 4; k++) step(0, S_STEP, k, 0);
        step(1, S_STEP, 50, 0);
        @(negedge clk_in);
        chk("t6_acc", 32'(bus.acc), 32'd0);
        chk("t6_err", 32'(bus.err), 32'd0);
        step(0, S_IDLE, 0, 0);

        // Random sequences against the model
        for (int r = 0; r < 150; r++) begin
            n = $urandom_range(0, 99);
            if (n < 4) begin
                step(1, S_IDLE, 0, $urandom_range(0, 7));
            end else if (n < 12) begin
                step(0, S_LOAD, $urandom_range(0, 255), $urandom_range(0, 7));
            end else if (n < 16) begin
                step(0, rand_illegal(), $urandom_range(0, 255), $urandom_range(0, 7));
            end else if (n < 22) begin
                step(0, S_IDLE, $urandom_range(0, 255), $urandom_range(0, 7));
            end else begin
                step(0, S_RS, $urandom_range(0, 255), $urandom_range(0, 7));
                for (int k = 0; k < int'($urandom_range(0, 8)); k++) begin
                    if ($urandom_range(0, 5) == 0)
                        step(0, S_IDLE, $urandom_range(0, 255), $urandom_range(0, 7));
                    step(0, S_STEP, $urandom_range(0, 255), $urandom_range(0, 7));
                end
                step(0, S_RE, $urandom_range(0, 255), $urandom_range(0, 7));
            end
        end

        step(0, S_IDLE, 0, 0);
        repeat (2) @(negedge clk_in);
        chk("row_q_drained", 32'(row_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
